bit_reverse_printer: RTL and testbench

//  Parametrised successor of the 8-bit ASCII bit-reversal printer. Sits between uart_rx and

---
 rtl/bit_reverse_pkg.sv | 23 ++
 rtl/bit_reverse_printer_if.sv | 30 +++
 rtl/bit_reverse.sv | 14 +
 rtl/bit_reverse_printer.sv | 129 ++++++++++++
 tb/tb_bit_reverse_printer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_reverse_pkg.sv
// Shared definitions for the bit-reversal printer: FSM encoding and the
// ASCII characters the block consumes and produces.
package bit_reverse_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_LATCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // True for the only two characters that carry a bit value.
    function automatic logic is_bit_char(input logic [7:0] c);
        return (c == ASCII_ZERO) || (c == ASCII_ONE);
    endfunction

endpackage

// File: rtl/bit_reverse_printer_if.sv
// Bundle of the uart-side signals of the bit-reversal printer.
// master = the environment (uart_rx / uart_tx side), slave = the printer.
interface bit_reverse_printer_if #(
    parameter int WIDTH = 8
);
    localparam int BCW = $clog2(WIDTH + 1);

    logic [7:0]       rx_data;
    logic             new_rx_data;
    logic             mode;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic             new_tx_data;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic [BCW-1:0]   bit_count;
    logic             err_char;
    logic             overrun;

    modport master (
        output rx_data, new_rx_data, mode, tx_busy,
        input  tx_data, new_tx_data, word_out, word_valid, bit_count, err_char, overrun
    );

    modport slave (
        input  rx_data, new_rx_data, mode, tx_busy,
        output tx_data, new_tx_data, word_out, word_valid, bit_count, err_char, overrun
    );

endinterface

// File: rtl/bit_reverse.sv
// Purely combinational bit-order reversal: dout[i] = din[WIDTH-1-i].
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // One wire per bit; no logic, just a crossing of the bus.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule

// File: rtl/bit_reverse_printer.sv
// Collects WIDTH ASCII '0'/'1' characters into a word, optionally reverses
// it, and streams it back as ASCII (plus optional CR/LF) under tx_busy
// flow control. All outputs are registered.
module bit_reverse_printer
    import bit_reverse_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit APPEND_CRLF = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    bit_reverse_printer_if.slave bus
);

    localparam int BCW   = $clog2(WIDTH + 1);
    localparam int TOTAL = WIDTH + (APPEND_CRLF ? 2 : 0);
    localparam int IW    = $clog2(TOTAL + 1);

    state_t           state;
    logic [WIDTH-1:0] shift_q;      // word being collected, first char ends in MSB
    logic [WIDTH-1:0] tx_shift_q;   // word being sent, MSB is the next bit char
    logic [WIDTH-1:0] reversed;
    logic             mode_q;
    logic [BCW-1:0]   bit_count_q;
    logic [IW-1:0]    idx_q;
    logic [7:0]       next_char;

    logic [7:0]       tx_data_q;
    logic             new_tx_q;
    logic [WIDTH-1:0] word_out_q;
    logic             word_valid_q;
    logic             err_q;
    logic             overrun_q;

    bit_reverse #(.WIDTH(WIDTH)) u_rev (
        .din  (shift_q),
        .dout (reversed)
    );

    // Character for the current send index: a bit char, then CR, then LF.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        next_char = tx_shift_q[WIDTH-1] ? ASCII_ONE : ASCII_ZERO;
        if (APPEND_CRLF && idx_q == IW'(WIDTH))
            next_char = ASCII_CR;
        else if (APPEND_CRLF && idx_q == IW'(WIDTH + 1))
            next_char = ASCII_LF;
    end

    // Control FSM with registered outputs; strobes default low every cycle.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_COLLECT;
            shift_q      <= '0;
            tx_shift_q   <= '0;
            mode_q       <= 1'b0;
            bit_count_q  <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            new_tx_q     <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            new_tx_q     <= 1'b0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;

            case (state)
                ST_COLLECT: begin
                    if (bus.new_rx_data) begin
                        if (is_bit_char(bus.rx_data)) begin
                            shift_q     <= {shift_q[WIDTH-2:0], bus.rx_data[0]};
                            bit_count_q <= bit_count_q + BCW'(1);
                            if (bit_count_q == '0)
                                mode_q <= bus.mode;
                            if (bit_count_q == BCW'(WIDTH - 1))
                                state <= ST_LATCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    word_out_q   <= mode_q ? shift_q : reversed;
                    tx_shift_q   <= mode_q ? shift_q : reversed;
                    word_valid_q <= 1'b1;
                    bit_count_q  <= '0;
                    idx_q        <= '0;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= next_char;
                        new_tx_q   <= 1'b1;
                        idx_q      <= idx_q + IW'(1);
                        tx_shift_q <= tx_shift_q << 1;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= (idx_q == IW'(TOTAL)) ? ST_DONE : ST_SEND;
                end
                ST_DONE: begin
                    state <= ST_COLLECT;
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase

            // Characters arriving while the word is being echoed are dropped.
            if (bus.new_rx_data && state != ST_COLLECT)
                overrun_q <= 1'b1;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_q;
    assign bus.word_out    = word_out_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.bit_count   = bit_count_q;
    assign bus.err_char    = err_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_bit_reverse_printer.sv
// Directed bench for bit_reverse_printer: an 8-bit instance with CR/LF and a
// 4-bit instance without. Inputs change 2 ns after the rising edge; outputs
// are read at that point or on the falling edge.
module tb_bit_reverse_printer;
    import bit_reverse_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_reverse_printer_if #(.WIDTH(8)) bus8 ();
    bit_reverse_printer_if #(.WIDTH(4)) bus4 ();

    bit_reverse_printer #(.WIDTH(8), .APPEND_CRLF(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    bit_reverse_printer #(.WIDTH(4), .APPEND_CRLF(1'b0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Monitor state.
    logic [7:0] q8[$];
    logic [7:0] q4[$];
    int         valid8_cnt  = 0;
    logic [7:0] last_word8  = '0;
    logic [3:0] last_word4  = '0;
    int         err_cnt     = 0;
    int         ovr_cnt     = 0;
    int         consec_viol = 0;
    int         busy_viol   = 0;
    int         first_tx_cyc = -1;
    int         last_rx_cyc  = 0;
    logic       prev_tx8   = 1'b0;
    logic       prev_busy8 = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus8.new_tx_data) begin
            q8.push_back(bus8.tx_data);
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            if (prev_tx8) consec_viol++;
            if (prev_busy8) busy_viol++;
        end
        if (bus8.word_valid) begin
            valid8_cnt++;
            last_word8 = bus8.word_out;
        end
        if (bus8.err_char) err_cnt++;
        if (bus8.overrun)  ovr_cnt++;
        prev_tx8   = bus8.new_tx_data;
        prev_busy8 = bus8.tx_busy;
        if (bus4.new_tx_data) q4.push_back(bus4.tx_data);
        if (bus4.word_valid)  last_word4 = bus4.word_out;
    end

    typedef struct {
        string      name;
        logic       mode;
        logic [7:0] bits;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_char8(input logic [7:0] c);
        bus8.rx_data     = c;
        bus8.new_rx_data = 1'b1;
        last_rx_cyc      = cyc;
        step();
        bus8.new_rx_data = 1'b0;
    endtask

    task automatic send_char4(input logic [7:0] c);
        bus4.rx_data     = c;
        bus4.new_rx_data = 1'b1;
        step();
        bus4.new_rx_data = 1'b0;
    endtask

    task automatic wait_tx8(input int n, input int budget);
        int k = 0;
        while (q8.size() < n && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_tx8: timeout got %0d chars expected %0d", q8.size(), n);
        end
    endtask

    // Expected echo of an 8-bit word: bit chars MSB first, then CR, LF.
    task automatic check_tx8(input string tag, input logic [7:0] w);
        logic [7:0] exp_q[$];
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i] ? ASCII_ONE : ASCII_ZERO);
        exp_q.push_back(ASCII_CR);
        exp_q.push_back(ASCII_LF);
        check({tag, "_len"}, q8.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q8.size(); i++)
            check($sformatf("%s_ch%0d", tag, i), q8[i], exp_q[i]);
    endtask

    task automatic start_word8(input logic m, input logic [7:0] bits);
        q8.delete();
        bus8.mode = m;
        for (int i = 7; i >= 0; i--) begin
            send_char8(bits[i] ? ASCII_ONE : ASCII_ZERO);
            bus8.mode = ~m;   // mode only counts at the first char
        end
    endtask

    task automatic run_word8(input string tag, input logic m, input logic [7:0] bits,
                             input logic [7:0] exp_w);
        int v0;
        v0 = valid8_cnt;
        start_word8(m, bits);
        wait_tx8(10, 200);
        idle(4);
        check({tag, "_word"}, last_word8, exp_w);
        check({tag, "_word_out"}, bus8.word_out, exp_w);
        check({tag, "_valid_cnt"}, valid8_cnt - v0, 1);
        check_tx8(tag, exp_w);
    endtask

    initial begin
        int sz, e0, o0, v0;

        vecs[0] = '{"aa_rev",   1'b0, 8'hAA, 8'h55};
        vecs[1] = '{"e0_pass",  1'b1, 8'hE0, 8'hE0};
        vecs[2] = '{"e0_rev",   1'b0, 8'hE0, 8'h07};
        vecs[3] = '{"f0_rev",   1'b0, 8'hF0, 8'h0F};
        vecs[4] = '{"5a_pass",  1'b1, 8'h5A, 8'h5A};
        vecs[5] = '{"01_rev",   1'b0, 8'h01, 8'h80};
        vecs[6] = '{"c5_rev",   1'b0, 8'hC5, 8'hA3};

        rst = 1'b1;
        bus8.rx_data = '0; bus8.new_rx_data = 1'b0; bus8.mode = 1'b0; bus8.tx_busy = 1'b0;
        bus4.rx_data = '0; bus4.new_rx_data = 1'b0; bus4.mode = 1'b0; bus4.tx_busy = 1'b0;
        idle(3);
        check("rst_tx_data",   bus8.tx_data, 0);
        check("rst_new_tx",    bus8.new_tx_data, 0);
        check("rst_word_out",  bus8.word_out, 0);
        check("rst_bit_count", bus8.bit_count, 0);
        check("rst_flags",     {bus8.word_valid, bus8.err_char, bus8.overrun}, 0);
        rst = 1'b0;
        idle(2);

        // Table vectors, with first-char latency measured on the first one.
        for (int v = 0; v < 7; v++) begin
            first_tx_cyc = -1;
            run_word8(vecs[v].name, vecs[v].mode, vecs[v].bits, vecs[v].exp_word);
            if (v == 0) check("latency", first_tx_cyc - last_rx_cyc, 3);
        end

        // Invalid character inside a word is flagged and ignored.
        q8.delete();
        e0 = err_cnt;
        v0 = valid8_cnt;
        bus8.mode = 1'b0;
        send_char8(ASCII_ONE);
        send_char8(8'h78);
        step();
        check("err_pulse", err_cnt - e0, 1);
        check("err_bit_count", bus8.bit_count, 1);
        send_char8(ASCII_ZERO); send_char8(ASCII_ONE); send_char8(ASCII_ZERO);
        send_char8(ASCII_ONE);  send_char8(ASCII_ZERO); send_char8(ASCII_ONE);
        check("err_seven_count", bus8.bit_count, 7);
        check("err_no_word_yet", valid8_cnt - v0, 0);
        send_char8(ASCII_ZERO);
        wait_tx8(10, 200);
        idle(4);
        check("err_word", last_word8, 8'h55);
        check_tx8("err", 8'h55);

        // Long tx_busy stall in the middle of the echo.
        start_word8(1'b0, 8'hC5);
        wait_tx8(3, 200);
        bus8.tx_busy = 1'b1;
        idle(2);
        sz = q8.size();
        idle(200);
        check("busy_hold", q8.size(), sz);
        bus8.tx_busy = 1'b0;
        wait_tx8(10, 200);
        idle(4);
        check_tx8("busy", 8'hA3);

        // Character during SEND: overrun, dropped, next word unaffected.
        o0 = ovr_cnt;
        start_word8(1'b1, 8'hAA);
        wait_tx8(1, 200);
        send_char8(ASCII_ONE);
        wait_tx8(10, 200);
        idle(4);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check_tx8("ovr", 8'hAA);
        check("ovr_bit_count", bus8.bit_count, 0);
        run_word8("after_ovr", 1'b0, 8'h01, 8'h80);

        // Reset after five characters.
        bus8.mode = 1'b0;
        for (int i = 0; i < 5; i++) send_char8(ASCII_ONE);
        check("mid_bit_count", bus8.bit_count, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst5_bit_count", bus8.bit_count, 0);
        check("rst5_word_out",  bus8.word_out, 0);

        // Reset in the middle of the echo.
        start_word8(1'b0, 8'hAA);
        wait_tx8(2, 200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sz = q8.size();
        check("rsts_new_tx",   bus8.new_tx_data, 0);
        check("rsts_tx_data",  bus8.tx_data, 0);
        check("rsts_word_out", bus8.word_out, 0);
        idle(30);
        check("rsts_silent", q8.size(), sz);
        run_word8("fresh", 1'b0, 8'hF0, 8'h0F);

        // 4-bit instance without CR/LF: "1000" -> "0001".
        q4.delete();
        bus4.mode = 1'b0;
        send_char4(ASCII_ONE);
        send_char4(ASCII_ZERO);
        send_char4(ASCII_ZERO);
        send_char4(ASCII_ZERO);
        idle(40);
        check("w4_word", last_word4, 4'h1);
        check("w4_len", q4.size(), 4);
        if (q4.size() == 4) begin
            check("w4_ch0", q4[0], ASCII_ZERO);
            check("w4_ch1", q4[1], ASCII_ZERO);
            check("w4_ch2", q4[2], ASCII_ZERO);
            check("w4_ch3", q4[3], ASCII_ONE);
        end

        check("no_consec_tx", consec_viol, 0);
        check("no_tx_when_busy", busy_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
